// File: rtl/pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_stepper
// Purpose  : Steps one PLL output (PSSEL/PSDIR/PSPULSE) to a requested
//            absolute phase position, taking the shortest way round the
//            phase circle and tracking the current position.
// Revision : 1.0 - initial release
// ============================================================================
module pll_phase_stepper #(
    parameter int PHASE_STEPS = 80,
    parameter int INIT_POS    = 68,
    parameter int PS_SEL      = 2,
    parameter int DIR_UP      = 0,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_HI    = 4,
    parameter int PULSE_LO    = 4,
    parameter int SETTLE_CYC  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [6:0] req_pos,
    output logic       req_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] cur_pos,
    output logic [2:0] ps_sel,
    output logic       ps_dir,
    output logic       ps_pulse
);

    localparam int         TW         = 8;
    localparam logic [6:0] c_steps    = 7'(PHASE_STEPS);
    localparam logic [6:0] c_half     = 7'(PHASE_STEPS / 2);
    localparam logic [6:0] c_last_pos = 7'(PHASE_STEPS - 1);
    localparam logic [6:0] c_init_pos = 7'(INIT_POS);
    localparam logic       c_dir_up   = 1'(DIR_UP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_PULSE_H = 3'd2,
        S_PULSE_L = 3'd3,
        S_SETTLE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [6:0]      r_pos;
    logic [6:0]      r_steps;
    logic            r_up;
    logic            r_err;
    logic            r_pulse;

    logic            w_accept;
    logic            w_timer_zero;
    logic            w_in_range;
    logic [6:0]      w_diff;
    logic [6:0]      w_up_dist;
    logic            w_zero;
    logic            w_go_up;
    logic [6:0]      w_n;
    logic [6:0]      w_pos_step;

    // Cycles spent in each timed state, loaded as (duration - 1) on entry
    function automatic logic [TW-1:0] f_dur(input state_t s);
        case (s)
            S_SETUP:   f_dur = TW'(SETUP_CYC - 1);
            S_PULSE_H: f_dur = TW'(PULSE_HI - 1);
            S_PULSE_L: f_dur = TW'(PULSE_LO - 1);
            S_SETTLE:  f_dur = TW'(SETTLE_CYC - 1);
            default:   f_dur = '0;
        endcase
    endfunction

    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_timer_zero = (r_timer == '0);

    // Shortest-path planning: forward distance on the circle, ties go up
    always_comb begin
        w_in_range = (req_pos < c_steps);
        w_diff     = req_pos - r_pos;
        w_up_dist  = (req_pos < r_pos) ? (w_diff + c_steps) : w_diff;
        w_zero     = !w_in_range || (w_up_dist == 7'd0);
        w_go_up    = (w_up_dist <= c_half);
        w_n        = w_go_up ? w_up_dist : (c_steps - w_up_dist);
    end

    // Next tracked position for one pulse in the latched direction
    always_comb begin
        if (r_up) begin
            w_pos_step = (r_pos == c_last_pos) ? 7'd0 : (r_pos + 7'd1);
        end else begin
            w_pos_step = (r_pos == 7'd0) ? c_last_pos : (r_pos - 7'd1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_timer_zero) w_state_nxt = S_PULSE_H;
            end
            S_PULSE_H: begin
                if (w_timer_zero) begin
                    w_state_nxt = (r_steps > 7'd1) ? S_PULSE_L : S_SETTLE;
                end
            end
            S_PULSE_L: begin
                if (w_timer_zero) w_state_nxt = S_PULSE_H;
            end
            S_SETTLE: begin
                if (w_timer_zero) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-state cycle timer, reloaded whenever the state changes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= f_dur(w_state_nxt);
        end else if (!w_timer_zero) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    // Request latching, position tracking and the registered pulse output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos   <= c_init_pos;
            r_steps <= 7'd0;
            r_up    <= 1'b1;
            r_err   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= (w_state_nxt == S_PULSE_H);
            if (w_accept) begin
                r_steps <= w_zero ? 7'd0 : w_n;
                r_err   <= !w_in_range;
                // Direction only changes for real moves, so degenerate
                // requests leave ps_dir untouched
                if (!w_zero) r_up <= w_go_up;
            end else if ((r_state == S_PULSE_H) && w_timer_zero) begin
                r_pos   <= w_pos_step;
                r_steps <= r_steps - 7'd1;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE) || w_accept;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) && r_err;
    assign cur_pos   = r_pos;
    assign ps_sel    = 3'(PS_SEL);
    assign ps_dir    = r_up ? c_dir_up : ~c_dir_up;
    assign ps_pulse  = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_phase_stepper
// Purpose  : Scoreboard bench for pll_phase_stepper: expectations are queued
//            at each accepted request and compared when done fires; pulse
//            shape and per-pulse position are checked as they occur.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_phase_stepper;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [6:0] req_pos;
    logic       req_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] cur_pos;
    logic [2:0] ps_sel;
    logic       ps_dir;
    logic       ps_pulse;

    pll_phase_stepper dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_pos   (req_pos),
        .req_ready (req_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cur_pos   (cur_pos),
        .ps_sel    (ps_sel),
        .ps_dir    (ps_dir),
        .ps_pulse  (ps_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int fin;
        bit e_err;
        int n;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   m_pos = 68;
    bit   m_dn  = 1'b0;
    int   hi_len = 0;
    int   lo_len = 0;
    int   op_pulses = 0;
    bit   prev_p = 1'b0;
    int   n_acc = 0;
    int   last_done_cyc = 0;
    int   acc_gap = 0;
    int   up;
    exp_t e;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            m_pos = 68;
            prev_p = 1'b0;
            hi_len = 0;
            lo_len = 0;
            op_pulses = 0;
        end else begin
            if (sb.size() > 0) begin
                check_eq("ready_low_while_busy", req_ready, 0);
                check_eq("busy_high_in_op", busy, 1);
            end
            if (ps_pulse) begin
                if (!prev_p && op_pulses > 0) check_eq("pulse_gap", lo_len, 4);
                hi_len++;
            end else begin
                if (prev_p) begin
                    check_eq("pulse_width", hi_len, 4);
                    m_pos = m_dn ? (m_pos + 79) % 80 : (m_pos + 1) % 80;
                    check_eq("step_pos", cur_pos, m_pos);
                    check_eq("step_dir", ps_dir, m_dn ? 1 : 0);
                    op_pulses++;
                    hi_len = 0;
                    lo_len = 0;
                end
                lo_len++;
            end
            prev_p = ps_pulse;
            if (done) begin
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    check_eq("done_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("done_cycle", cyc, e.due);
                    check_eq("final_pos", cur_pos, e.fin);
                    check_eq("err_flag", err, e.e_err);
                    check_eq("pulse_count", op_pulses, e.n);
                    check_eq("ps_sel", ps_sel, 2);
                end
            end else if (err) begin
                check_eq("err_without_done", 1, 0);
            end
            if (req_valid && req_ready) begin
                n_acc++;
                acc_gap = cyc - last_done_cyc;
                e.e_err = (req_pos >= 7'd80);
                up = e.e_err ? 0 : ((int'(req_pos) - m_pos + 80) % 80);
                if (up == 0) begin
                    e.n = 0;
                end else if (up <= 40) begin
                    e.n = up;
                    m_dn = 1'b0;
                end else begin
                    e.n = 80 - up;
                    m_dn = 1'b1;
                end
                e.fin = e.e_err ? m_pos : int'(req_pos);
                e.due = cyc + ((e.n == 0) ? 1 : (1 + 2 + e.n * 4 + (e.n - 1) * 4 + 64));
                sb.push_back(e);
                op_pulses = 0;
            end
        end
    end

    // Present a request and hold it until the handshake completes
    task automatic do_req(input int pos);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_pos   = 7'(pos);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("done_timeout", 0, 1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_cur_pos", cur_pos, 68);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pulse", ps_pulse, 0);
        check_eq("rst_dir", ps_dir, 0);
    endtask

    initial begin
        int acc0;
        bit seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_pos   = 7'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("init_cur_pos", cur_pos, 68);
        check_eq("init_ready", req_ready, 1);
        check_eq("init_busy", busy, 0);
        check_eq("init_done", done, 0);
        check_eq("init_err", err, 0);
        check_eq("init_pulse", ps_pulse, 0);
        check_eq("init_dir", ps_dir, 0);
        check_eq("init_sel", ps_sel, 2);

        // Reset in the middle of a pulse
        do_req(70);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ps_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("saw_pulse", seen, 1);
        apply_reset();

        // Short move up: 2 pulses, done at A+79
        do_req(70);
        wait_done();

        // Wrap up 68 -> 4, then down to 0, then the tie 0 -> 40
        apply_reset();
        do_req(4);
        wait_done();
        do_req(0);
        wait_done();
        do_req(40);
        wait_done();

        // Shortest path down through the wrap 10 -> 60
        do_req(10);
        wait_done();
        do_req(60);
        wait_done();

        // Degenerate requests
        apply_reset();
        do_req(68);
        wait_done();
        do_req(80);
        wait_done();
        do_req(127);
        wait_done();

        // Back-pressure: second request held through the first move
        acc0 = n_acc;
        do_req(70);
        do_req(66);
        check_eq("reaccept_gap", acc_gap, 1);
        wait_done();
        repeat (5) @(negedge clk);
        check_eq("accept_count", n_acc - acc0, 2);
        check_eq("bp_final_pos", cur_pos, 66);
        check_eq("bp_idle_ready", req_ready, 1);
        check_eq("bp_queue_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
